// File: rtl/axi_throughput_meter_pkg.sv
// rtl/axi_throughput_meter_pkg.sv - shared types for the AXI throughput meter
package axi_throughput_meter_pkg;

  // Fields are sized for the widest supported counter; narrower builds zero-extend.
  localparam int MAX_CNT_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 sat;
    logic [MAX_CNT_W-1:0] w_beats;
    logic [MAX_CNT_W-1:0] w_bursts;
    logic [MAX_CNT_W-1:0] w_stalls;
    logic [MAX_CNT_W-1:0] r_beats;
    logic [MAX_CNT_W-1:0] r_bursts;
    logic [MAX_CNT_W-1:0] r_stalls;
  } cnt_set_t;

endpackage

// File: rtl/axi_port_counter.sv
// rtl/axi_port_counter.sv - six saturating beat/burst/stall counters for one AXI port
module axi_port_counter
  import axi_throughput_meter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic     aclk,
  input  logic     areset,
  input  logic     clr,
  input  logic     en,
  input  logic     wvalid,
  input  logic     wready,
  input  logic     wlast,
  input  logic     rvalid,
  input  logic     rready,
  input  logic     rlast,
  output cnt_set_t nxt
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [5:0][CNT_W-1:0] cnt_q;
  logic [5:0][CNT_W-1:0] cnt_d;
  logic [5:0]            inc;
  logic                  sat_q;
  logic                  sat_d;

  always_comb begin
    inc = {rvalid & ~rready, rvalid & rready & rlast, rvalid & rready,
           wvalid & ~wready, wvalid & wready & wlast, wvalid & wready};
    sat_d = clr ? 1'b0 : sat_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = clr ? '0 : cnt_q[i];
      if (!clr && en && inc[i] && (cnt_q[i] != CMAX))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      if (cnt_d[i] == CMAX)
        sat_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // Next-state values are exported so the top can capture the final counted cycle.
  always_comb begin
    nxt          = '0;
    nxt.sat      = sat_d;
    nxt.w_beats  = MAX_CNT_W'(cnt_d[0]);
    nxt.w_bursts = MAX_CNT_W'(cnt_d[1]);
    nxt.w_stalls = MAX_CNT_W'(cnt_d[2]);
    nxt.r_beats  = MAX_CNT_W'(cnt_d[3]);
    nxt.r_bursts = MAX_CNT_W'(cnt_d[4]);
    nxt.r_stalls = MAX_CNT_W'(cnt_d[5]);
  end

endmodule

// File: rtl/axi_throughput_meter.sv
// rtl/axi_throughput_meter.sv - windowed per-port AXI W/R beat, burst and stall meter
module axi_throughput_meter
  import axi_throughput_meter_pkg::*;
#(
  parameter int N_PORTS = 16,
  parameter int CNT_W   = 32,
  parameter int WIN_W   = 24
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIN_W-1:0]           window_len,
  input  logic [N_PORTS-1:0]         mon_wvalid,
  input  logic [N_PORTS-1:0]         mon_wready,
  input  logic [N_PORTS-1:0]         mon_wlast,
  input  logic [N_PORTS-1:0]         mon_rvalid,
  input  logic [N_PORTS-1:0]         mon_rready,
  input  logic [N_PORTS-1:0]         mon_rlast,
  input  logic [$clog2(N_PORTS)-1:0] sel,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           w_beats,
  output logic [CNT_W-1:0]           w_bursts,
  output logic [CNT_W-1:0]           w_stalls,
  output logic [CNT_W-1:0]           r_beats,
  output logic [CNT_W-1:0]           r_bursts,
  output logic [CNT_W-1:0]           r_stalls,
  output logic                       sat
);

  localparam int SEL_W = $clog2(N_PORTS);
  localparam logic [SEL_W:0] NP = (SEL_W + 1)'(N_PORTS);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic             done_q, done_d;
  logic             clr;
  logic             capture;
  cnt_set_t         live_nxt [N_PORTS];
  cnt_set_t         res_q    [N_PORTS];
  cnt_set_t         rd;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    axi_port_counter #(.CNT_W(CNT_W)) u_cnt (
      .aclk   (aclk),
      .areset (areset),
      .clr    (clr),
      .en     (state_q == RUN),
      .wvalid (mon_wvalid[g]),
      .wready (mon_wready[g]),
      .wlast  (mon_wlast[g]),
      .rvalid (mon_rvalid[g]),
      .rready (mon_rready[g]),
      .rlast  (mon_rlast[g]),
      .nxt    (live_nxt[g])
    );
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (window_len != '0)) begin
          state_d = RUN;
          timer_d = window_len;
          clr     = 1'b1;
        end
      end
      RUN: begin
        // Abort wins over a completion landing in the same cycle.
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == WIN_W'(1)) begin
          state_d = IDLE;
          timer_d = '0;
          capture = 1'b1;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - WIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      timer_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      if (capture)
        for (int i = 0; i < N_PORTS; i++) res_q[i] <= live_nxt[i];
    end
  end

  always_comb begin
    rd = '0;
    if ({1'b0, sel} < NP) rd = res_q[sel];
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign w_beats  = CNT_W'(rd.w_beats);
  assign w_bursts = CNT_W'(rd.w_bursts);
  assign w_stalls = CNT_W'(rd.w_stalls);
  assign r_beats  = CNT_W'(rd.r_beats);
  assign r_bursts = CNT_W'(rd.r_bursts);
  assign r_stalls = CNT_W'(rd.r_stalls);
  assign sat      = rd.sat;

endmodule

// File: tb/tb_axi_throughput_meter.sv
// tb/tb_axi_throughput_meter.sv - randomized self-checking bench for axi_throughput_meter
module tb_axi_throughput_meter;

  logic        aclk = 1'b0;
  logic        areset, start, start4, abort;
  logic [23:0] window_len;
  logic [15:0] wv, wr, wl, rv, rr, rl;
  logic [3:0]  sel;
  logic [2:0]  sel4;
  logic        busy, done, sat, busy4, done4, sat4;
  logic [31:0] w_beats, w_bursts, w_stalls, r_beats, r_bursts, r_stalls;
  logic [3:0]  w_beats4, w_bursts4, w_stalls4, r_beats4, r_bursts4, r_stalls4;
  logic [192:0] act, act4;

  int n_checks = 0;
  int n_fail   = 0;

  longint live_m [16][6];
  longint res_m  [16][6];
  longint res4_m [6][6];

  always #50 aclk = ~aclk;

  axi_throughput_meter #(.N_PORTS(16), .CNT_W(32), .WIN_W(24)) dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort), .window_len(window_len),
    .mon_wvalid(wv), .mon_wready(wr), .mon_wlast(wl),
    .mon_rvalid(rv), .mon_rready(rr), .mon_rlast(rl), .sel(sel),
    .busy(busy), .done(done), .w_beats(w_beats), .w_bursts(w_bursts), .w_stalls(w_stalls),
    .r_beats(r_beats), .r_bursts(r_bursts), .r_stalls(r_stalls), .sat(sat)
  );

  axi_throughput_meter #(.N_PORTS(6), .CNT_W(4), .WIN_W(8)) dut4 (
    .aclk(aclk), .areset(areset), .start(start4), .abort(abort), .window_len(window_len[7:0]),
    .mon_wvalid(wv[5:0]), .mon_wready(wr[5:0]), .mon_wlast(wl[5:0]),
    .mon_rvalid(rv[5:0]), .mon_rready(rr[5:0]), .mon_rlast(rl[5:0]), .sel(sel4),
    .busy(busy4), .done(done4), .w_beats(w_beats4), .w_bursts(w_bursts4), .w_stalls(w_stalls4),
    .r_beats(r_beats4), .r_bursts(r_bursts4), .r_stalls(r_stalls4), .sat(sat4)
  );

  assign act  = {sat, w_beats, w_bursts, w_stalls, r_beats, r_bursts, r_stalls};
  assign act4 = {sat4, 28'd0, w_beats4, 28'd0, w_bursts4, 28'd0, w_stalls4,
                 28'd0, r_beats4, 28'd0, r_bursts4, 28'd0, r_stalls4};

  // Expected readout: unbounded model counts clipped to the counter maximum.
  function automatic logic [192:0] exp_vec(input int p, input bit is4);
    logic [192:0] v;
    longint mx, c;
    v  = '0;
    mx = is4 ? 64'd15 : 64'hFFFF_FFFF;
    if (p >= (is4 ? 6 : 16)) return v;
    for (int f = 0; f < 6; f++) begin
      c = is4 ? res4_m[p][f] : res_m[p][f];
      if (c >= mx) begin
        c      = mx;
        v[192] = 1'b1;
      end
      v[32*(5-f) +: 32] = c[31:0];
    end
    return v;
  endfunction

  task automatic drive(input int mode, input int c);
    wv = '0; wr = '0; wl = '0; rv = '0; rr = '0; rl = '0;
    case (mode)
      1: begin
        wv = 16'h0008; wr = 16'h0008;
        wl = (c % 4 == 0) ? 16'h0008 : 16'h0000;
      end
      2: begin
        rv = 16'h0001;
        rr = (c % 2 == 1) ? 16'h0001 : 16'h0000;
      end
      3: begin
        wv = 16'($urandom); wr = 16'($urandom); wl = 16'($urandom);
        rv = 16'($urandom); rr = 16'($urandom); rl = 16'($urandom);
      end
      4: begin
        wv = '1; wr = '1;
      end
      default: ;
    endcase
  endtask

  task automatic clear_live();
    for (int p = 0; p < 16; p++)
      for (int f = 0; f < 6; f++) live_m[p][f] = 0;
  endtask

  task automatic accumulate();
    for (int p = 0; p < 16; p++) begin
      live_m[p][0] += longint'(wv[p] & wr[p]);
      live_m[p][1] += longint'(wv[p] & wr[p] & wl[p]);
      live_m[p][2] += longint'(wv[p] & ~wr[p]);
      live_m[p][3] += longint'(rv[p] & rr[p]);
      live_m[p][4] += longint'(rv[p] & rr[p] & rl[p]);
      live_m[p][5] += longint'(rv[p] & ~rr[p]);
    end
  endtask

  task automatic commit(input bit use4);
    for (int p = 0; p < 16; p++)
      for (int f = 0; f < 6; f++)
        if (use4) begin
          if (p < 6) res4_m[p][f] = live_m[p][f];
        end else res_m[p][f] = live_m[p][f];
  endtask

  task automatic clear_results();
    for (int p = 0; p < 16; p++)
      for (int f = 0; f < 6; f++) begin
        res_m[p][f] = 0;
        if (p < 6) res4_m[p][f] = 0;
      end
  endtask

  // Accepts a window at cycle k, drives len counted cycles, returns at the negedge of k+len+1.
  task automatic run_window(input int len, input int mode, input bit use4, output int busy_seen);
    busy_seen = 0;
    @(negedge aclk);
    if (use4) start4 = 1'b1; else start = 1'b1;
    window_len = 24'(len);
    drive(3, 0);
    clear_live();
    @(negedge aclk);
    start  = 1'b0;
    start4 = 1'b0;
    for (int c = 1; c <= len; c++) begin
      drive(mode, c);
      accumulate();
      busy_seen += int'(use4 ? busy4 : busy);
      @(negedge aclk);
    end
    drive(0, 0);
    commit(use4);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    n_checks++;
    if ({busy, done, busy4, done4} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, busy4, done4});
    end
    clear_results();
    for (int p = 0; p < 16; p++) begin
      sel = 4'(p); #1;
      n_checks++;
      if (act !== exp_vec(p, 0)) begin
        n_fail++;
        $display("FAIL reset_results port %0d: got %h expected %h", p, act, exp_vec(p, 0));
      end
    end
    areset = 1'b0;
  endtask

  task automatic test_burst_pattern();
    int bs;
    run_window(10, 1, 0, bs);
    n_checks++;
    if (bs !== 10 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_timing: busy_cycles=%0d done=%b busy=%b expected 10 1 0", bs, done, busy);
    end
    sel = 4'd3; #1;
    n_checks++;
    if ({w_beats, w_bursts, w_stalls} !== {32'd10, 32'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL burst_port3: got %0d %0d %0d expected 10 2 0", w_beats, w_bursts, w_stalls);
    end
    for (int p = 0; p < 16; p++) begin
      sel = 4'(p); #1;
      n_checks++;
      if (act !== exp_vec(p, 0)) begin
        n_fail++;
        $display("FAIL burst_all port %0d: got %h expected %h", p, act, exp_vec(p, 0));
      end
    end
    @(negedge aclk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_rready_toggle();
    int bs;
    run_window(8, 2, 0, bs);
    sel = 4'd0; #1;
    n_checks++;
    if ({done, r_beats, r_stalls} !== {1'b1, 32'd4, 32'd4}) begin
      n_fail++;
      $display("FAIL toggle_port0: done=%b r_beats=%0d r_stalls=%0d expected 1 4 4", done, r_beats, r_stalls);
    end
    for (int p = 1; p < 16; p++) begin
      sel = 4'(p); #1;
      n_checks++;
      if (act !== '0) begin
        n_fail++;
        $display("FAIL toggle_other port %0d: got %h expected 0", p, act);
      end
    end
  endtask

  task automatic test_random();
    int bs, len;
    for (int w = 0; w < 4; w++) begin
      len = $urandom_range(1, 40);
      run_window(len, 3, 0, bs);
      n_checks++;
      if (bs !== len || done !== 1'b1) begin
        n_fail++;
        $display("FAIL random_timing: busy_cycles=%0d done=%b expected %0d 1", bs, done, len);
      end
      for (int p = 0; p < 16; p++) begin
        sel = 4'(p); #1;
        n_checks++;
        if (act !== exp_vec(p, 0)) begin
          n_fail++;
          $display("FAIL random_win%0d port %0d: got %h expected %h", w, p, act, exp_vec(p, 0));
        end
      end
    end
  endtask

  task automatic test_saturation();
    int bs;
    int lens [2] = '{20, 5};
    for (int w = 0; w < 2; w++) begin
      run_window(lens[w], 4, 1, bs);
      sel4 = 3'd0; #1;
      n_checks++;
      if ({done4, w_beats4, sat4} !== {1'b1, (w == 0) ? 4'd15 : 4'd5, (w == 0)}) begin
        n_fail++;
        $display("FAIL sat_win%0d: done=%b w_beats=%0d sat=%b", w, done4, w_beats4, sat4);
      end
      for (int p = 0; p < 8; p++) begin
        sel4 = 3'(p); #1;
        n_checks++;
        if (act4 !== exp_vec(p, 1)) begin
          n_fail++;
          $display("FAIL sat_all%0d port %0d: got %h expected %h", w, p, act4, exp_vec(p, 1));
        end
      end
    end
  endtask

  task automatic test_abort();
    bit done_seen;
    @(negedge aclk);
    start = 1'b1; window_len = 24'd10; drive(3, 0);
    @(negedge aclk);
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      drive(3, c);
      abort = (c == 5);
      @(negedge aclk);
    end
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got %b expected 0", busy);
    end
    done_seen = done;
    repeat (8) begin
      @(negedge aclk);
      done_seen |= done;
    end
    drive(0, 0);
    n_checks++;
    if (done_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: got %b expected 0", done_seen);
    end
    for (int p = 0; p < 16; p++) begin
      sel = 4'(p); #1;
      n_checks++;
      if (act !== exp_vec(p, 0)) begin
        n_fail++;
        $display("FAIL abort_hold port %0d: got %h expected %h", p, act, exp_vec(p, 0));
      end
    end
  endtask

  task automatic test_reset_midwindow();
    bit seen;
    @(negedge aclk);
    start = 1'b1; window_len = 24'd10; drive(3, 0);
    @(negedge aclk);
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      drive(3, c);
      areset = (c == 3);
      @(negedge aclk);
    end
    areset = 1'b0;
    clear_results();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_busy: got %b expected 0", busy);
    end
    for (int p = 0; p < 16; p++) begin
      sel = 4'(p); #1;
      n_checks++;
      if (act !== exp_vec(p, 0)) begin
        n_fail++;
        $display("FAIL midreset_results port %0d: got %h expected %h", p, act, exp_vec(p, 0));
      end
    end
    start = 1'b1; window_len = 24'd0;
    @(negedge aclk);
    start = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      seen |= busy | done;
      @(negedge aclk);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: busy_or_done=%b expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge aclk);
    start = 1'b1; window_len = 24'd3; drive(3, 0);
    clear_live();
    for (int t = 1; t <= 12; t++) begin
      @(negedge aclk);
      if (t % 4 == 0) begin
        n_checks++;
        if ({done, busy} !== 2'b10) begin
          n_fail++;
          $display("FAIL b2b_done t=%0d: done,busy=%b expected 10", t, {done, busy});
        end
        commit(0);
        for (int p = 0; p < 16; p++) begin
          sel = 4'(p); #1;
          n_checks++;
          if (act !== exp_vec(p, 0)) begin
            n_fail++;
            $display("FAIL b2b_results t=%0d port %0d: got %h expected %h", t, p, act, exp_vec(p, 0));
          end
        end
        clear_live();
        if (t == 12) start = 1'b0;
        drive(3, 0);
      end else begin
        n_checks++;
        if ({done, busy} !== 2'b01) begin
          n_fail++;
          $display("FAIL b2b_run t=%0d: done,busy=%b expected 01", t, {done, busy});
        end
        drive(3, t);
        accumulate();
      end
    end
    @(negedge aclk);
    drive(0, 0);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_stop: done,busy=%b expected 00", {done, busy});
    end
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; start4 = 1'b0; abort = 1'b0;
    window_len = '0; sel = '0; sel4 = '0;
    drive(0, 0);
    clear_live();
    test_reset();
    test_burst_pattern();
    test_rready_toggle();
    test_random();
    test_saturation();
    test_abort();
    test_reset_midwindow();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
